// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: constants and types shared by the USB full-speed
// transmit and receive paths.
package usb_fs_pkg;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Normal form polynomial, plus the reflected form used for LSB-first shifting
    localparam logic [15:0] CRC16_POLY          = 16'h8005;
    localparam logic [15:0] CRC16_POLY_REFL     = 16'hA001;
    localparam logic [15:0] CRC16_PRESET        = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL      = 16'h800D;
    localparam logic [15:0] CRC16_RESIDUAL_REFL = 16'hB001;

    // {dp, dn}
    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10
    } line_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP
    } tx_state_e;

    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_fs_crc16_serial.sv
// usb_fs_crc16_serial: bit-serial USB CRC16, LSB-first data, register
// kept in reflected form so the low byte is sent first.
module usb_fs_crc16_serial
    import usb_fs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        fb    = crc_q[0] ^ din;
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC16_PRESET;
        end else if (bit_en) begin
            crc_d = (crc_q >> 1) ^ (fb ? CRC16_POLY_REFL : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC16_PRESET;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_fs_tx_engine.sv
// usb_fs_tx_engine: full-speed packet serialiser with bit stuffing,
// NRZI encoding, CRC16 append and EOP generation.
module usb_fs_tx_engine
    import usb_fs_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_pkt_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_data_avail,
    output logic       tx_data_get,
    input  logic [7:0] tx_data,
    output logic       tx_pkt_end,
    output logic       usb_tx_en,
    output logic       usb_dp_out,
    output logic       usb_dn_out
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLK_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    ones_q, ones_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    pid_q, pid_d;
    logic          nrzi_q, nrzi_d;
    logic          tx_en_q, tx_en_d;
    logic          end_q, end_d;
    line_e         line_q, line_d;

    logic       bit_end, byte_end, stuff;
    logic       emit, emit_bit, load, go_eop;
    logic [7:0] load_byte;
    logic       crc_clr, crc_en;
    logic [15:0] crc;

    assign bit_end  = (clk_cnt_q == CLK_LAST);
    assign byte_end = (bit_cnt_q == 3'd7);
    assign stuff    = (ones_q == 3'd6);

    usb_fs_crc16_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (crc_clr),
        .bit_en (crc_en),
        .din    (emit_bit),
        .crc    (crc)
    );

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = bit_end ? '0 : clk_cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        ones_d      = ones_q;
        shift_d     = shift_q;
        pid_d       = pid_q;
        nrzi_d      = nrzi_q;
        tx_en_d     = tx_en_q;
        end_d       = 1'b0;
        line_d      = line_q;
        emit        = 1'b0;
        emit_bit    = 1'b0;
        load        = 1'b0;
        go_eop      = 1'b0;
        load_byte   = shift_q;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        tx_data_get = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (tx_pkt_start) begin
                    state_d   = ST_SYNC;
                    pid_d     = tx_pid;
                    tx_en_d   = 1'b1;
                    crc_clr   = 1'b1;
                    load      = 1'b1;
                    load_byte = SYNC_BYTE;
                end
            end
            ST_EOP: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd1) begin
                        line_d = LINE_J;
                        nrzi_d = 1'b1;
                    end
                    if (bit_cnt_q == 3'd2) begin
                        state_d   = ST_IDLE;
                        tx_en_d   = 1'b0;
                        end_d     = 1'b1;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            default: begin
                if (bit_end) begin
                    // A pending stuff bit holds the data bit counter
                    if (stuff) begin
                        emit = 1'b1;
                    end else if (!byte_end) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        emit      = 1'b1;
                        emit_bit  = shift_q[1];
                        crc_en    = (state_q == ST_DATA);
                    end else begin
                        unique case (state_q)
                            ST_SYNC: begin
                                state_d   = ST_PID;
                                load      = 1'b1;
                                load_byte = pid_byte(pid_q);
                            end
                            ST_PID, ST_DATA: begin
                                if (state_q == ST_PID && pid_q[1:0] != 2'b11) begin
                                    go_eop = 1'b1;
                                end else if (tx_data_avail) begin
                                    state_d     = ST_DATA;
                                    tx_data_get = 1'b1;
                                    load        = 1'b1;
                                    load_byte   = tx_data;
                                    crc_en      = 1'b1;
                                end else begin
                                    state_d   = ST_CRC_LO;
                                    load      = 1'b1;
                                    load_byte = ~crc[7:0];
                                end
                            end
                            ST_CRC_LO: begin
                                state_d   = ST_CRC_HI;
                                load      = 1'b1;
                                load_byte = ~crc[15:8];
                            end
                            default: go_eop = 1'b1;
                        endcase
                    end
                end
            end
        endcase

        if (go_eop) begin
            state_d   = ST_EOP;
            bit_cnt_d = 3'd0;
            ones_d    = 3'd0;
            line_d    = LINE_SE0;
        end

        if (load) begin
            shift_d   = load_byte;
            bit_cnt_d = 3'd0;
            emit      = 1'b1;
            emit_bit  = load_byte[0];
        end

        // NRZI: a zero toggles the line, a one holds it
        if (emit) begin
            ones_d = emit_bit ? ones_q + 3'd1 : 3'd0;
            nrzi_d = emit_bit ? nrzi_q : ~nrzi_q;
            line_d = nrzi_d ? LINE_J : LINE_K;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            ones_q    <= 3'd0;
            shift_q   <= 8'h00;
            pid_q     <= 4'h0;
            nrzi_q    <= 1'b1;
            tx_en_q   <= 1'b0;
            end_q     <= 1'b0;
            line_q    <= LINE_J;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            shift_q   <= shift_d;
            pid_q     <= pid_d;
            nrzi_q    <= nrzi_d;
            tx_en_q   <= tx_en_d;
            end_q     <= end_d;
            line_q    <= line_d;
        end
    end

    assign usb_tx_en  = tx_en_q;
    assign tx_pkt_end = end_q;
    assign usb_dp_out = line_q[1];
    assign usb_dn_out = line_q[0];

endmodule

// File: tb/tb_usb_fs_tx_engine.sv
// tb_usb_fs_tx_engine: directed packets, line decoder and byte
// scoreboard for the full-speed transmit engine.
module tb_usb_fs_tx_engine;
    import usb_fs_pkg::*;

    localparam int CPB = 4;
    typedef logic [7:0] u8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_pkt_start = 1'b0;
    logic [3:0] tx_pid = 4'h0;
    logic       tx_data_avail = 1'b0;
    logic       tx_data_get;
    logic [7:0] tx_data = 8'h00;
    logic       tx_pkt_end;
    logic       usb_tx_en;
    logic       usb_dp_out;
    logic       usb_dn_out;

    usb_fs_tx_engine #(.CLK_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_pkt_start  (tx_pkt_start),
        .tx_pid        (tx_pid),
        .tx_data_avail (tx_data_avail),
        .tx_data_get   (tx_data_get),
        .tx_data       (tx_data),
        .tx_pkt_end    (tx_pkt_end),
        .usb_tx_en     (usb_tx_en),
        .usb_dp_out    (usb_dp_out),
        .usb_dn_out    (usb_dn_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_get = 0;
    int n_end = 0;
    int n_pkt = 0;
    int n_abort = 0;
    int m_len, m_stuff, m_bits, t0, t_end, gap;
    int exp_stuff;
    bit avail_en = 1'b0;
    logic get_seen = 1'b0;

    u8 exp_q[$];
    u8 got_q[$];
    u8 pay_q[$];
    u8 up_q[$];
    u8 pkt_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expire(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (tx_pkt_end) n_end++;

    // Upstream byte source: pops on each get strobe
    always @(negedge clk) begin
        get_seen = tx_data_get;
        if (tx_data_get) begin
            n_get++;
            check("get_while_avail", {31'd0, tx_data_avail}, 32'd1);
        end
    end

    always @(posedge clk) begin
        if (get_seen && up_q.size() > 0) void'(up_q.pop_front());
        #1;
        tx_data_avail = avail_en && (up_q.size() > 0);
        tx_data = (up_q.size() > 0) ? up_q[0] : 8'h00;
    end

    // MSB-first form of the CRC, fed LSB-first bytes
    function automatic logic [15:0] crc_msb_pay();
        logic [15:0] c = CRC16_PRESET;
        logic fb;
        foreach (pay_q[i])
            for (int k = 0; k < 8; k++) begin
                fb = c[15] ^ pay_q[i][k];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ CRC16_POLY;
            end
        return c;
    endfunction

    function automatic logic [15:0] crc_msb_got(input int from);
        logic [15:0] c = CRC16_PRESET;
        logic fb;
        for (int i = from; i < got_q.size(); i++)
            for (int k = 0; k < 8; k++) begin
                fb = c[15] ^ got_q[i][k];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ CRC16_POLY;
            end
        return c;
    endfunction

    function automatic logic [15:0] crc_tx_val();
        logic [15:0] c = crc_msb_pay();
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[k] = c[15-k];
        return ~r;
    endfunction

    function automatic int stuff_model();
        int ones = 0;
        int s = 0;
        foreach (pkt_q[i])
            for (int k = 0; k < 8; k++) begin
                if (pkt_q[i][k]) begin
                    ones++;
                    if (ones == 6) begin
                        s++;
                        ones = 0;
                    end
                end else begin
                    ones = 0;
                end
            end
        return s;
    endfunction

    task automatic push_exp(input logic [3:0] pid);
        logic [15:0] c;
        pkt_q.delete();
        pkt_q.push_back(8'h80);
        pkt_q.push_back({~pid, pid});
        if (pid[1:0] == 2'b11) begin
            c = crc_tx_val();
            foreach (pay_q[i]) pkt_q.push_back(pay_q[i]);
            pkt_q.push_back(c[7:0]);
            pkt_q.push_back(c[15:8]);
        end
        foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
        exp_stuff = stuff_model();
    endtask

    task automatic drive_start(input logic [3:0] pid);
        @(negedge clk);
        tx_pid = pid;
        tx_pkt_start = 1'b1;
        @(negedge clk);
        tx_pkt_start = 1'b0;
    endtask

    task automatic start_pkt(input logic [3:0] pid, input bit avail);
        push_exp(pid);
        up_q = pay_q;
        avail_en = avail;
        drive_start(pid);
    endtask

    task automatic wait_pkts(input int target);
        int i = 0;
        while (n_pkt < target && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("pkt_done", n_pkt, target);
    endtask

    // Line decoder: NRZI decode, destuff, pop expected bytes
    initial begin : mon
        logic prev, b;
        logic [7:0] sh;
        int nb, ones, guard;
        bit aborted;
        forever begin
            @(negedge clk);
            if (usb_tx_en) begin
                t0 = cyc;
                gap = t0 - t_end;
                got_q.delete();
                prev = 1'b1;
                ones = 0;
                nb = 0;
                sh = 8'h00;
                m_stuff = 0;
                m_bits = 0;
                guard = 0;
                aborted = 1'b0;
                forever begin
                    if (!usb_tx_en) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (!usb_dp_out && !usb_dn_out) break;
                    if (guard > 300) begin
                        expire("mon_eop");
                        aborted = 1'b1;
                        break;
                    end
                    b = (usb_dp_out == prev);
                    prev = usb_dp_out;
                    m_bits++;
                    if (ones == 6) begin
                        m_stuff++;
                        ones = 0;
                        check("stuff_bit", {31'd0, b}, 32'd0);
                    end else begin
                        ones = b ? ones + 1 : 0;
                        sh = {b, sh[7:1]};
                        nb++;
                        if (nb == 8) begin
                            nb = 0;
                            got_q.push_back(sh);
                            if (exp_q.size() == 0) check("unexpected_byte", sh, 32'hFFFF_FFFF);
                            else check("byte", sh, exp_q.pop_front());
                        end
                    end
                    guard++;
                    repeat (CPB) @(negedge clk);
                end
                if (aborted) begin
                    n_abort++;
                end else begin
                    check("eop_align", nb, 0);
                    repeat (CPB) @(negedge clk);
                    check("eop_se0", {usb_dp_out, usb_dn_out, usb_tx_en}, 3'b001);
                    repeat (CPB) @(negedge clk);
                    check("eop_j", {usb_dp_out, usb_dn_out, usb_tx_en}, 3'b101);
                    repeat (CPB) @(negedge clk);
                    check("pkt_end", {usb_tx_en, tx_pkt_end}, 2'b01);
                    m_len = cyc - t0;
                    t_end = cyc;
                    n_pkt++;
                end
            end
        end
    end

    initial begin : main
        int base, g0, e0, i;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx_en", usb_tx_en, 0);
        check("rst_dp", usb_dp_out, 1);
        check("rst_dn", usb_dn_out, 0);
        check("rst_end", tx_pkt_end, 0);
        check("rst_get", tx_data_get, 0);

        // ACK handshake
        pay_q.delete();
        start_pkt(PID_ACK, 1'b0);
        wait_pkts(1);
        check("ack_len", m_len, 76);
        check("ack_stuff", m_stuff, 0);
        check("ack_bits", m_bits, 16);
        check("ack_get", n_get, 0);
        check("ack_left", exp_q.size(), 0);

        // DATA1 zero length
        start_pkt(PID_DATA1, 1'b0);
        wait_pkts(2);
        check("zlp_bits", m_bits - m_stuff, 32);
        check("zlp_get", n_get, 0);
        check("zlp_left", exp_q.size(), 0);

        // DATA0 00 01 02 03
        pay_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        start_pkt(PID_DATA0, 1'b1);
        wait_pkts(3);
        check("d4_get", n_get, 4);
        check("d4_residual", crc_msb_got(2), CRC16_RESIDUAL);
        check("d4_left", exp_q.size(), 0);

        // DATA0 FF FF: stuffing across a byte boundary
        pay_q = '{8'hFF, 8'hFF};
        g0 = n_get;
        start_pkt(PID_DATA0, 1'b1);
        wait_pkts(4);
        check("ff_get", n_get - g0, 2);
        check("ff_stuff", m_stuff, exp_stuff);
        check("ff_min_stuff", m_stuff >= 3, 1);
        check("ff_bits", m_bits, 48 + exp_stuff);
        check("ff_residual", crc_msb_got(2), CRC16_RESIDUAL);

        // NAK with a stray start mid-packet
        pay_q.delete();
        avail_en = 1'b0;
        push_exp(PID_NAK);
        drive_start(PID_NAK);
        repeat (20) @(negedge clk);
        tx_pid = PID_STALL;
        tx_pkt_start = 1'b1;
        @(negedge clk);
        tx_pkt_start = 1'b0;
        wait_pkts(5);
        check("stray_len", m_len, 76);
        repeat (60) @(negedge clk);
        check("stray_no_pkt", n_pkt, 5);
        check("stray_idle", usb_tx_en, 0);

        // Reset during the PID byte
        e0 = n_end;
        exp_q.push_back(8'h80);
        drive_start(PID_ACK);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_line", {usb_tx_en, usb_dp_out, usb_dn_out}, 3'b010);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_rst_no_end", n_end, e0);
        check("mid_rst_abort", n_abort, 1);
        check("mid_rst_left", exp_q.size(), 0);

        // Normal NAK after the reset
        start_pkt(PID_NAK, 1'b0);
        wait_pkts(6);
        check("nak_pid", got_q[1], 8'h5A);
        check("nak_len", m_len, 76);

        // Back-to-back NAK then STALL
        base = n_pkt;
        start_pkt(PID_NAK, 1'b0);
        i = 0;
        while (!tx_pkt_end && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!tx_pkt_end) expire("b2b_end");
        push_exp(PID_STALL);
        tx_pid = PID_STALL;
        tx_pkt_start = 1'b1;
        @(negedge clk);
        tx_pkt_start = 1'b0;
        check("b2b_en_next", usb_tx_en, 1);
        wait_pkts(base + 2);
        check("b2b_gap", gap, 1);
        check("b2b_len", m_len, 76);
        check("b2b_pid", got_q[1], 8'h1E);
        check("b2b_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
